// File: rtl/mux_arbiter_pkg.sv
// Shared types and helpers for the two-requester round-robin mux arbiter.
package mux_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  // Tenure counter width; a BURST of 1 still needs a 1-bit register.
  function automatic int cnt_width(input int burst);
    int w;
    w = $clog2(burst + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mux_arbiter_if.sv
// Requester-side handshake and shared data path between two producers and the arbiter.
interface mux_arb_if #(parameter int W = 8);
  logic         req0;
  logic         req1;
  logic [W-1:0] in0;
  logic [W-1:0] in1;
  logic         gnt0;
  logic         gnt1;
  logic         sel;
  logic [W-1:0] out;
  logic         out_valid;

  modport master (
    output req0, req1, in0, in1,
    input  gnt0, gnt1, sel, out, out_valid
  );

  modport slave (
    input  req0, req1, in0, in1,
    output gnt0, gnt1, sel, out, out_valid
  );
endinterface

// File: rtl/mux_arbiter_rr_pick2.sv
// Combinational two-way round-robin pick: a lone request wins, a tie goes to the one not served last.
module rr_pick2 (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_i,
  output logic pick0_o,
  output logic pick1_o
);

  assign pick0_o = req0_i & (~req1_i | last_i);
  assign pick1_o = req1_i & (~req0_i | ~last_i);

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin owner of a 2:1 mux select with bounded tenures and a registered data output.
//
// state | meaning
// IDLE  | no owner; sel holds its previous value
// OWN0  | requester 0 owns the path, sel = 0
// OWN1  | requester 1 owns the path, sel = 1
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int W     = 8,
  parameter int BURST = 4
) (
  input logic   clk,
  input logic   rst_n,
  mux_arb_if.slave bus
);

  localparam int         CNT_W  = cnt_width(BURST);
  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_OWN0 = OWN0;
  localparam logic [1:0] S_OWN1 = OWN1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             sel_q, sel_d;
  logic [W-1:0]     out_q, out_d;
  logic             vld_q, vld_d;

  logic own_q, own_req, in_tenure, beat, tenure_end, last_eff;
  logic pick0, pick1;

  assign own_q      = (state_q == S_OWN1);
  assign own_req    = own_q ? bus.req1 : bus.req0;
  assign in_tenure  = (state_q != S_IDLE);
  assign beat       = in_tenure & own_req;
  assign tenure_end = in_tenure & (~own_req | (cnt_q == CNT_W'(BURST - 1)));
  // The finishing owner counts as served before the tie is broken.
  assign last_eff   = tenure_end ? own_q : last_q;

  rr_pick2 u_pick (
    .req0_i  (bus.req0),
    .req1_i  (bus.req1),
    .last_i  (last_eff),
    .pick0_o (pick0),
    .pick1_o (pick1)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    sel_d   = sel_q;
    out_d   = out_q;
    vld_d   = 1'b0;

    if (beat) begin
      out_d = sel_q ? bus.in1 : bus.in0;
      vld_d = 1'b1;
      cnt_d = cnt_q + CNT_W'(1);
    end

    if ((state_q == S_IDLE) || tenure_end) begin
      if (tenure_end) begin
        last_d = own_q;
        cnt_d  = '0;
      end
      if (pick0) begin
        state_d = S_OWN0;
        sel_d   = 1'b0;
      end else if (pick1) begin
        state_d = S_OWN1;
        sel_d   = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.gnt0      = (state_q == S_OWN0);
  assign bus.gnt1      = (state_q == S_OWN1);
  assign bus.sel       = sel_q;
  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;

endmodule
